// File: rtl/mix_sequencer_pkg.sv
// Shared types for the voice mixer: sample width, sample type and sequencer states.
package mix_sequencer_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    SCALE
  } state_t;

endpackage

// File: rtl/mix_sequencer_clip.sv
// Saturating clipper: folds a 17-bit signed sum back into the 16-bit sample range.
module mix_sequencer_clip
  import mix_sequencer_pkg::*;
(
  input  logic signed [SAMPLE_W:0] i_sum,
  output sample_t                  o_sat,
  output logic                     o_clip
);

  // NOTE: every output gets a value on every path through always_comb, so no latch is inferred.
  always_comb begin
    o_clip = i_sum[SAMPLE_W] ^ i_sum[SAMPLE_W-1];
    case (i_sum[SAMPLE_W -: 2])
      2'b10:   o_sat = {1'b1, {(SAMPLE_W-1){1'b0}}};
      2'b01:   o_sat = {1'b0, {(SAMPLE_W-1){1'b1}}};
      default: o_sat = i_sum[SAMPLE_W-1:0];
    endcase
  end

endmodule

// File: rtl/mix_sequencer.sv
// Time-multiplexed mixer: sums NUM_CH channels one per cycle through a shared
// saturating adder, then applies a master volume.
module mix_sequencer
  import mix_sequencer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int VOL_W  = 4
) (
  input  logic                       iClk,
  input  logic                       iRst,
  input  logic                       iStart,
  input  logic [SAMPLE_W*NUM_CH-1:0] iChSample,
  input  logic [VOL_W-1:0]           iVolume,
  output logic                       oBusy,
  output sample_t                    oOut,
  output logic                       oValid,
  output logic                       oClipped,
  output logic                       oOverrun
);

  localparam int IDX_W  = $clog2(NUM_CH);
  localparam int PROD_W = SAMPLE_W + VOL_W + 1;

  state_t             r_state;
  state_t             w_next_state;
  logic               w_accept;
  logic               w_last;
  logic [IDX_W-1:0]   r_idx;
  sample_t            r_acc;
  sample_t            r_ch [NUM_CH];
  logic [VOL_W-1:0]   r_vol;
  logic               r_clip;

  logic signed [SAMPLE_W:0] w_sum;
  sample_t                  w_sat;
  logic                     w_clip;
  logic signed [PROD_W-1:0] w_acc_ext;
  logic signed [PROD_W-1:0] w_vol_ext;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] w_scaled;

  assign oBusy  = (r_state != IDLE);
  assign w_last = (r_idx == IDX_W'(NUM_CH - 1));
  assign w_sum  = {r_acc[SAMPLE_W-1], r_acc} + {r_ch[r_idx][SAMPLE_W-1], r_ch[r_idx]};

  mix_sequencer_clip u_clip (
    .i_sum  (w_sum),
    .o_sat  (w_sat),
    .o_clip (w_clip)
  );

  // Volume is unsigned: zero-extend it so the signed multiply treats it as positive.
  assign w_acc_ext = {{(VOL_W+1){r_acc[SAMPLE_W-1]}}, r_acc};
  assign w_vol_ext = {{(SAMPLE_W+1){1'b0}}, r_vol};
  assign w_prod    = w_acc_ext * w_vol_ext;
  assign w_scaled  = w_prod >>> VOL_W;

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (iStart) begin
          w_next_state = ACC;
          w_accept     = 1'b1;
        end
      end
      ACC:     if (w_last) w_next_state = SCALE;
      SCALE:   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: the shadow sample array is reset along with the rest so no flop powers up unknown.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_idx    <= '0;
      r_acc    <= '0;
      r_vol    <= '0;
      r_clip   <= 1'b0;
      oOut     <= '0;
      oValid   <= 1'b0;
      oClipped <= 1'b0;
      oOverrun <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) r_ch[k] <= '0;
    end else begin
      oValid   <= 1'b0;
      oOverrun <= iStart && oBusy;
      if (w_accept) begin
        for (int k = 0; k < NUM_CH; k++) r_ch[k] <= iChSample[SAMPLE_W*k +: SAMPLE_W];
        r_vol  <= iVolume;
        r_acc  <= '0;
        r_clip <= 1'b0;
        r_idx  <= '0;
      end
      if (r_state == ACC) begin
        r_acc  <= w_sat;
        r_clip <= r_clip | w_clip;
        r_idx  <= r_idx + IDX_W'(1);
      end
      if (r_state == SCALE) begin
        oOut     <= w_scaled[SAMPLE_W-1:0];
        oClipped <= r_clip;
        oValid   <= 1'b1;
      end
    end
  end

endmodule

// File: doc/mix_sequencer.md
Name: mix_sequencer

Overview:
- Time-multiplexed voice mixer front end. Per audio sample it sums NUM_CH signed 16-bit channel samples through one shared 17-bit adder and saturating clipper, one channel per cycle, then applies a 4-bit master volume.
- Sits between the voice/filter outputs and the DAC/PWM output stage.
- Replaces NUM_CH parallel adders with one adder, a small FSM and a channel counter.

Parameters:
- NUM_CH, 4, number of channels summed per frame (2..8).
- VOL_W, 4, master volume width; gain = vol / 2^VOL_W.

Ports:
- iClk  input  1  system clock.
- iRst  input  1  reset, asynchronous, active-high.
- iStart  input  1  frame request, single-cycle pulse per audio sample.
- iChSample  input  16*NUM_CH  packed signed channel samples; channel k at [16k+15:16k].
- iVolume  input  VOL_W  unsigned master volume.
- oBusy  output  1  high while a frame is in progress (ACC or SCALE).
- oOut  output  16  signed mixed sample, held between frames.
- oValid  output  1  one-cycle pulse when oOut updates.
- oClipped  output  1  frame saturated at least once; updates with oValid.
- oOverrun  output  1  one-cycle pulse when iStart is dropped.

Behaviour:
- Reset (async, iRst=1): state IDLE; idx, acc, oOut and all flags are 0. Reset mid-frame aborts the frame and no oValid is produced.

States:
- IDLE: iStart=1 latches iChSample and iVolume into shadow registers, clears acc and the clip flag, sets idx=0, moves to ACC. Inputs may change after the iStart cycle.
- ACC: sum = sext17(acc) + sext17(ch[idx]).
  - acc <= saturate(sum): 0x8000 when sum[16:15]=10, 0x7FFF when sum[16:15]=01, else sum[15:0].
  - Clip flag |= (sum[16] != sum[15]).
  - idx increments. Go to SCALE after channel NUM_CH-1 is processed.
- SCALE: p = signed(acc) * unsigned(vol), (16+VOL_W) bits.
  - oOut <= p >>> VOL_W (arithmetic shift, floor). This cannot overflow.
  - oClipped <= clip flag; oValid <= 1; state goes to IDLE.
- Saturation is applied after every add, so results depend on channel order, ascending from channel 0. This is intentional and bit-exact.

Timing:
- iStart sampled high in cycle T → ACC occupies cycles T+1..T+NUM_CH, SCALE is cycle T+NUM_CH+1, oValid is high in cycle T+NUM_CH+2.
- Latency is NUM_CH+2 cycles; oBusy is high from T+1 through T+NUM_CH+1.

Input handling:
- iStart while oBusy=1 is ignored and oOverrun pulses in the same cycle's registered output (next cycle). The in-flight frame is unaffected.
- iStart in the cycle oValid is high is accepted, since state is IDLE. Back-to-back throughput is one frame per NUM_CH+2 cycles.

Outputs:
- oValid is never high for more than one cycle.
- oOut and oClipped hold their values until the next SCALE.

Decomposition:
- Shared mixer package holds SAMPLE_W=16, the sample typedef (signed 16-bit), and the state enum {IDLE, ACC, SCALE}.
- Natural sub-module: reuse the existing clipper for the 17→16 saturation. The multiply-shift stays inline.

Test Plan:
- Basic sum: ch = 0x1000 ×4, vol=8, iStart at T → oValid at T+6 only, oOut=0x2000, oClipped=0; oBusy high T+1..T+5.
- Positive clip then recovery: ch0..3 = 0x7000, 0x7000, 0x9000, 0x0000, vol=15 → acc sequence 0x7000, 0x7FFF, 0x0FFF, 0x0FFF; oOut=0x0EFF, oClipped=1.
- Negative clip: ch = 0xA000 ×4, vol=15 → acc pinned at 0x8000; oOut=0x8800, oClipped=1. Same channels with vol=0 → oOut=0x0000. Full positive 0x7FFF with vol=15 → 0x77FF.
- Overrun: iStart at T, second iStart at T+3 → oOverrun pulses once, exactly one oValid at T+6 with the first frame's result. iStart at T+6 (with oValid) → accepted, next oValid at T+12.
- Input latching: change iChSample and iVolume at T+1 → result reflects values sampled at T.
- Reset mid-frame: assert iRst asynchronously at T+3 → all outputs 0 immediately, no oValid follows. A new iStart after release produces a correct frame.
